// File: rtl/hilo_commit.sv
// ============================================================================
// Module   : hilo_commit
// Brief    : Architectural HI/LO registers with multiply commit tracking,
//            MTHI/MTLO writes, accumulate feedback and RAW stall request.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hilo_commit #(
    parameter int W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       stall,
    input  logic             flush,
    input  logic             ex_mul_valid,
    input  logic [1:0]       ex_mul_op,
    input  logic [2*W-1:0]   mul_z,
    input  logic [1:0]       mt_we,
    input  logic [W-1:0]     mt_wdata,
    input  logic             mf_req,
    output logic [W-1:0]     hi,
    output logic [W-1:0]     lo,
    output logic [2*W-1:0]   hilo_fwd,
    output logic             stall_req
);

    localparam logic [1:0] C_OP_MULT = 2'b00;
    localparam logic       C_STOP    = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PEND = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [W-1:0]     r_hi;
    logic [W-1:0]     r_lo;
    logic [2*W-1:0]   r_hold;

    logic             w_issue;
    logic             w_stall_req;
    logic             w_commit;
    logic [2*W-1:0]   w_commit_val;
    logic             w_load_hold;
    logic             w_drop_hold;
    logic             w_mt_ok;
    logic             w_unused_stall;

    // Only the EX and MEM stall bits matter to this block.
    assign w_unused_stall = ^{stall[5:4], stall[1:0]};

    // Anything that reads HI/LO must wait while a commit is still outstanding;
    // a plain MULT overwrites HI/LO and so can follow back-to-back.
    assign w_stall_req = (r_state != S_IDLE) &&
                         ((ex_mul_valid && (ex_mul_op != C_OP_MULT)) || mf_req);

    assign w_issue = ex_mul_valid && (stall[2] != C_STOP) && !w_stall_req && !flush;
    assign w_mt_ok = (stall[3] != C_STOP) && !flush;

    always_comb begin
        w_next       = r_state;
        w_commit     = 1'b0;
        w_commit_val = mul_z;
        w_load_hold  = 1'b0;
        w_drop_hold  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_issue) begin
                    w_next = S_PEND;
                end
            end
            S_PEND: begin
                if (flush) begin
                    w_next = S_IDLE;
                end else if (stall[3] == C_STOP) begin
                    w_next      = S_HOLD;
                    w_load_hold = 1'b1;
                end else begin
                    w_commit = 1'b1;
                    w_next   = w_issue ? S_PEND : S_IDLE;
                end
            end
            S_HOLD: begin
                if (flush) begin
                    w_next      = S_IDLE;
                    w_drop_hold = 1'b1;
                end else if (stall[3] != C_STOP) begin
                    w_commit     = 1'b1;
                    w_commit_val = r_hold;
                    w_next       = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold <= '0;
        end else if (w_load_hold) begin
            r_hold <= mul_z;
        end else if (w_drop_hold) begin
            r_hold <= '0;
        end
    end

    // The MT op is always older than a committing multiply, so the multiply wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_commit) begin
            r_hi <= w_commit_val[2*W-1:W];
            r_lo <= w_commit_val[W-1:0];
        end else if (w_mt_ok) begin
            if (mt_we[1]) begin
                r_hi <= mt_wdata;
            end
            if (mt_we[0]) begin
                r_lo <= mt_wdata;
            end
        end
    end

    assign hi        = r_hi;
    assign lo        = r_lo;
    assign hilo_fwd  = {r_hi, r_lo};
    assign stall_req = w_stall_req;

endmodule

`default_nettype wire

// File: tb/tb_hilo_commit.sv
// ============================================================================
// Module   : tb_hilo_commit
// Brief    : Directed cycle-by-cycle vector bench for hilo_commit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hilo_commit;

    localparam int         W      = 32;
    localparam logic [1:0] OP_MUL = 2'b00;
    localparam logic [1:0] OP_MAD = 2'b01;
    localparam logic [1:0] OP_MSB = 2'b10;
    localparam logic [5:0] ST_MEM = 6'b001111;
    localparam logic [5:0] ST_NO  = 6'b000000;

    logic             clk;
    logic             rst;
    logic [5:0]       stall;
    logic             flush;
    logic             ex_mul_valid;
    logic [1:0]       ex_mul_op;
    logic [2*W-1:0]   mul_z;
    logic [1:0]       mt_we;
    logic [W-1:0]     mt_wdata;
    logic             mf_req;
    logic [W-1:0]     hi;
    logic [W-1:0]     lo;
    logic [2*W-1:0]   hilo_fwd;
    logic             stall_req;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic           rst;
        logic [5:0]     stall;
        logic           flush;
        logic           mv;
        logic [1:0]     op;
        logic [63:0]    z;
        logic [1:0]     mtwe;
        logic [31:0]    mtd;
        logic           mf;
        logic [31:0]    eh;
        logic [31:0]    el;
        logic           es;
    } vec_t;

    vec_t vq[$];

    hilo_commit #(.W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .ex_mul_valid (ex_mul_valid),
        .ex_mul_op    (ex_mul_op),
        .mul_z        (mul_z),
        .mt_we        (mt_we),
        .mt_wdata     (mt_wdata),
        .mf_req       (mf_req),
        .hi           (hi),
        .lo           (lo),
        .hilo_fwd     (hilo_fwd),
        .stall_req    (stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [5:0] s, input logic f, input logic mv,
                       input logic [1:0] op, input logic [63:0] z, input logic [1:0] mtwe,
                       input logic [31:0] mtd, input logic mf, input logic [31:0] eh,
                       input logic [31:0] el, input logic es);
        vec_t v;
        v.rst = r; v.stall = s; v.flush = f; v.mv = mv; v.op = op; v.z = z;
        v.mtwe = mtwe; v.mtd = mtd; v.mf = mf; v.eh = eh; v.el = el; v.es = es;
        vq.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst; stall = v.stall; flush = v.flush; ex_mul_valid = v.mv;
        ex_mul_op = v.op; mul_z = v.z; mt_we = v.mtwe; mt_wdata = v.mtd; mf_req = v.mf;
    endtask

    task automatic check(input string name, input logic [31:0] eh, input logic [31:0] el,
                         input logic es);
        checks++;
        if (hi !== eh || lo !== el || stall_req !== es || hilo_fwd !== {eh, el}) begin
            errors++;
            $display("FAIL %s: hi=%h lo=%h fwd=%h sreq=%b, expected hi=%h lo=%h fwd=%h sreq=%b",
                     name, hi, lo, hilo_fwd, stall_req, eh, el, {eh, el}, es);
        end
    endtask

    initial begin
        vec_t idle;
        idle = '{rst: 1'b0, stall: ST_NO, flush: 1'b0, mv: 1'b0, op: OP_MUL, z: 64'h0,
                 mtwe: 2'b00, mtd: 32'h0, mf: 1'b0, eh: 32'h0, el: 32'h0, es: 1'b0};
        drive(idle);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);

        //  rst st     fl mv op      z                         mtwe  mtd           mf  hi            lo            sreq
        add(0, ST_NO,  0, 0, OP_MUL, 64'h0,                    2'b00, 32'h0,        0, 32'h0,        32'h0,        0);
        // MULT, commit at issue+2
        add(0, ST_NO,  0, 1, OP_MUL, 64'h0,                    2'b00, 32'h0,        0, 32'h0,        32'h0,        0);
        add(0, ST_NO,  0, 0, OP_MUL, 64'h00000002_00000003,    2'b00, 32'h0,        0, 32'h0,        32'h0,        0);
        add(0, ST_NO,  0, 0, OP_MUL, 64'h0,                    2'b00, 32'h0,        0, 32'h2,        32'h3,        0);
        // MULT then MADD: one stall cycle, MADD sees MULT result
        add(0, ST_NO,  0, 1, OP_MUL, 64'h0,                    2'b00, 32'h0,        0, 32'h2,        32'h3,        0);
        add(0, ST_NO,  0, 1, OP_MAD, 64'h00000010_00000020,    2'b00, 32'h0,        0, 32'h2,        32'h3,        1);
        add(0, ST_NO,  0, 1, OP_MAD, 64'h0,                    2'b00, 32'h0,        0, 32'h10,       32'h20,       0);
        add(0, ST_NO,  0, 0, OP_MUL, 64'h00000011_00000021,    2'b00, 32'h0,        0, 32'h10,       32'h20,       0);
        add(0, ST_NO,  0, 0, OP_MUL, 64'h0,                    2'b00, 32'h0,        0, 32'h11,       32'h21,       0);
        // MULT then MFHI
        add(0, ST_NO,  0, 1, OP_MUL, 64'h0,                    2'b00, 32'h0,        0, 32'h11,       32'h21,       0);
        add(0, ST_NO,  0, 0, OP_MUL, 64'h00000030_00000031,    2'b00, 32'h0,        1, 32'h11,       32'h21,       1);
        add(0, ST_NO,  0, 0, OP_MUL, 64'h0,                    2'b00, 32'h0,        1, 32'h30,       32'h31,       0);
        // MULT with 3-cycle MEM stall -> HOLD, held product commits
        add(0, ST_NO,  0, 1, OP_MUL, 64'h0,                    2'b00, 32'h0,        0, 32'h30,       32'h31,       0);
        add(0, ST_MEM, 0, 0, OP_MUL, 64'h00000040_00000041,    2'b00, 32'h0,        0, 32'h30,       32'h31,       0);
        add(0, ST_MEM, 0, 0, OP_MUL, 64'hDEADDEAD_DEADDEAD,    2'b00, 32'h0,        0, 32'h30,       32'h31,       0);
        add(0, ST_MEM, 0, 0, OP_MUL, 64'hDEADDEAD_DEADDEAD,    2'b00, 32'h0,        1, 32'h30,       32'h31,       1);
        add(0, ST_NO,  0, 0, OP_MUL, 64'hBEEFBEEF_BEEFBEEF,    2'b00, 32'h0,        0, 32'h30,       32'h31,       0);
        add(0, ST_NO,  0, 0, OP_MUL, 64'h0,                    2'b00, 32'h0,        0, 32'h40,       32'h41,       0);
        // MTHI / MTLO
        add(0, ST_NO,  0, 0, OP_MUL, 64'h0,                    2'b10, 32'hAAAAAAAA, 0, 32'h40,       32'h41,       0);
        add(0, ST_NO,  0, 0, OP_MUL, 64'h0,                    2'b01, 32'h55555555, 0, 32'hAAAAAAAA, 32'h41,       0);
        // MULT flushed in PEND
        add(0, ST_NO,  0, 1, OP_MSB, 64'h0,                    2'b00, 32'h0,        0, 32'hAAAAAAAA, 32'h55555555, 0);
        add(0, ST_NO,  1, 0, OP_MUL, 64'h00000077_00000077,    2'b00, 32'h0,        0, 32'hAAAAAAAA, 32'h55555555, 0);
        add(0, ST_NO,  0, 0, OP_MUL, 64'h00000077_00000077,    2'b00, 32'h0,        0, 32'hAAAAAAAA, 32'h55555555, 0);
        add(0, ST_NO,  0, 0, OP_MUL, 64'h0,                    2'b00, 32'h0,        1, 32'hAAAAAAAA, 32'h55555555, 0);
        // MTLO colliding with multiply commit
        add(0, ST_NO,  0, 1, OP_MUL, 64'h0,                    2'b00, 32'h0,        0, 32'hAAAAAAAA, 32'h55555555, 0);
        add(0, ST_NO,  0, 0, OP_MUL, 64'h00000001_00000009,    2'b01, 32'h12345678, 0, 32'hAAAAAAAA, 32'h55555555, 0);
        add(0, ST_NO,  0, 0, OP_MUL, 64'h0,                    2'b00, 32'h0,        0, 32'h1,        32'h9,        0);
        // back-to-back MULT
        add(0, ST_NO,  0, 1, OP_MUL, 64'h0,                    2'b00, 32'h0,        0, 32'h1,        32'h9,        0);
        add(0, ST_NO,  0, 1, OP_MUL, 64'h00000005_00000006,    2'b00, 32'h0,        0, 32'h1,        32'h9,        0);
        add(0, ST_NO,  0, 0, OP_MUL, 64'h00000007_00000008,    2'b00, 32'h0,        0, 32'h5,        32'h6,        0);
        add(0, ST_NO,  0, 0, OP_MUL, 64'h0,                    2'b00, 32'h0,        0, 32'h7,        32'h8,        0);
        // reset in PEND
        add(0, ST_NO,  0, 1, OP_MUL, 64'h0,                    2'b00, 32'h0,        0, 32'h7,        32'h8,        0);
        add(1, ST_NO,  0, 0, OP_MUL, 64'h00000009_00000009,    2'b00, 32'h0,        1, 32'h7,        32'h8,        1);
        add(0, ST_NO,  0, 0, OP_MUL, 64'h0,                    2'b00, 32'h0,        1, 32'h0,        32'h0,        0);
        // MT writes suppressed by MEM stall and by flush
        add(0, ST_MEM, 0, 0, OP_MUL, 64'h0,                    2'b11, 32'hCAFEF00D, 0, 32'h0,        32'h0,        0);
        add(0, ST_NO,  1, 0, OP_MUL, 64'h0,                    2'b11, 32'hCAFEF00D, 0, 32'h0,        32'h0,        0);
        add(0, ST_NO,  0, 0, OP_MUL, 64'h0,                    2'b00, 32'h0,        0, 32'h0,        32'h0,        0);

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i]);
            #1;
            check($sformatf("vec%0d", i), vq[i].eh, vq[i].el, vq[i].es);
            @(negedge clk);
        end

        // flush while holding: held product must be dropped
        drive(idle); ex_mul_valid = 1'b1;
        #1; check("hold_flush_issue", 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        drive(idle); stall = ST_MEM; mul_z = 64'h00000066_00000067;
        #1; check("hold_flush_pend", 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        drive(idle); stall = ST_MEM; mf_req = 1'b1;
        #1; check("hold_flush_hold", 32'h0, 32'h0, 1'b1);
        @(negedge clk);
        drive(idle); flush = 1'b1;
        #1; check("hold_flush_kill", 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        drive(idle); mf_req = 1'b1;
        #1; check("hold_flush_after", 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        drive(idle);
        #1; check("hold_flush_final", 32'h0, 32'h0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
